// File: rtl/mem_stage_multilane.sv
// N-lane MEM stage: EX/MEM bundle register, load-response wait/hold/drain control,
// load data alignment and per-lane forwarding/valid handshake toward WB.
module mem_stage_multilane #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int PAY_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        pre_valid_i,
  output logic                    now_allowin_o,
  input  logic                    next_allowin_i,
  output logic [LANES-1:0]        next_valid_o,
  input  logic                    excep_flush_i,
  input  logic [LANES-1:0]        ld_req_i,
  input  logic [LANES*3-1:0]      ld_op_i,
  input  logic [LANES*2-1:0]      addr_lo_i,
  input  logic [LANES*DATA_W-1:0] alu_res_i,
  input  logic [LANES*PAY_W-1:0]  payload_i,
  input  logic                    data_ok_i,
  input  logic [DATA_W-1:0]       rdata_i,
  output logic [LANES*DATA_W-1:0] wb_data_o,
  output logic [LANES*PAY_W-1:0]  payload_o,
  output logic [LANES-1:0]        fwd_valid_o,
  output logic [LANES-1:0]        fwd_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  function automatic logic [DATA_W-1:0] load_align(input logic [2:0]        op,
                                                   input logic [1:0]        addr_lo,
                                                   input logic [DATA_W-1:0] word);
    logic [7:0]               b;
    logic [15:0]              h;
    logic signed [DATA_W-1:0] sx;
    b  = 8'(word >> {addr_lo, 3'b000});
    h  = 16'(word >> {addr_lo[1], 4'b0000});
    sx = '0;
    case (op)
      3'd0: begin
        sx         = $signed(b);
        load_align = sx;
      end
      3'd1: load_align = DATA_W'(b);
      3'd2: begin
        sx         = $signed(h);
        load_align = sx;
      end
      3'd3:    load_align = DATA_W'(h);
      default: load_align = word;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES-1:0]        ld_lane_q, ld_lane_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic [LANES*PAY_W-1:0]  payload_q;
  logic [LANES*3-1:0]      ld_op_q;
  logic [LANES*2-1:0]      addr_lo_q;
  logic [LANES*DATA_W-1:0] alu_q;

  logic              ready;
  logic              allowin;
  logic              capture;
  logic              new_load;
  logic [DATA_W-1:0] ld_data;

  assign ready    = (state_q == S_IDLE) || (state_q == S_HOLD) ||
                    ((state_q == S_WAIT) && data_ok_i);
  assign allowin  = (!(|valid_q) || (ready && next_allowin_i)) &&
                    (state_q != S_DRAIN) && !excep_flush_i;
  assign capture  = allowin && (|pre_valid_i);
  assign new_load = capture && (|(ld_req_i & pre_valid_i));

  // Aligned view of the single in-flight load lane, taken live from the bus
  always_comb begin
    ld_data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (ld_lane_q[l]) ld_data = load_align(ld_op_q[l*3 +: 3], addr_lo_q[l*2 +: 2], rdata_i);
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    valid_d   = valid_q;
    ld_lane_d = ld_lane_q;
    if (excep_flush_i) begin
      valid_d   = '0;
      ld_lane_d = '0;
    end else if (allowin) begin
      valid_d   = pre_valid_i;
      ld_lane_d = ld_req_i & pre_valid_i;
    end
    case (state_q)
      S_IDLE: if (new_load) state_d = S_WAIT;
      S_WAIT: begin
        if (excep_flush_i) begin
          state_d = data_ok_i ? S_IDLE : S_DRAIN;
        end else if (data_ok_i) begin
          if (next_allowin_i) begin
            state_d = new_load ? S_WAIT : S_IDLE;
          end else begin
            state_d = S_HOLD;
            buf_d   = ld_data;
          end
        end
      end
      S_HOLD: begin
        if (excep_flush_i)       state_d = S_IDLE;
        else if (next_allowin_i) state_d = new_load ? S_WAIT : S_IDLE;
      end
      S_DRAIN: if (data_ok_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      ld_lane_q <= '0;
      buf_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ld_lane_q <= ld_lane_d;
      buf_q     <= buf_d;
      if (capture) payload_q <= payload_i;
      if (capture) assert ($onehot0(ld_req_i & pre_valid_i));
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      ld_op_q   <= ld_op_i;
      addr_lo_q <= addr_lo_i;
      alu_q     <= alu_res_i;
    end
  end

  // MEM -> WB boundary
  always_comb begin
    wb_data_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (valid_q[l]) begin
        if (ld_lane_q[l]) wb_data_o[l*DATA_W +: DATA_W] = (state_q == S_HOLD) ? buf_q : ld_data;
        else              wb_data_o[l*DATA_W +: DATA_W] = alu_q[l*DATA_W +: DATA_W];
      end
    end
  end

  assign now_allowin_o = allowin;
  assign next_valid_o  = valid_q & {LANES{ready && !excep_flush_i}};
  assign fwd_valid_o   = next_valid_o;
  assign fwd_busy_o    = valid_q & ld_lane_q & {LANES{!ready}};
  assign payload_o     = payload_q;

endmodule

// File: tb/tb_mem_stage_multilane.sv
// Bench for mem_stage_multilane: directed vector table, hand sequences and a random
// run, all checked against a transaction-level model of the stage.
module tb_mem_stage_multilane;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int PAY_W  = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LANES-1:0]        pre_valid, ld_req, next_valid_o, fwd_valid_o, fwd_busy_o;
  logic                    now_allowin_o, next_allowin, excep_flush, data_ok;
  logic [LANES*3-1:0]      ld_op;
  logic [LANES*2-1:0]      addr_lo;
  logic [LANES*DATA_W-1:0] alu_res, wb_data_o;
  logic [LANES*PAY_W-1:0]  payload, payload_o;
  logic [DATA_W-1:0]       rdata;

  always #5 clk = ~clk;

  mem_stage_multilane #(.LANES(LANES), .DATA_W(DATA_W), .PAY_W(PAY_W)) dut (
    .clk(clk), .rst(rst), .pre_valid_i(pre_valid), .now_allowin_o(now_allowin_o),
    .next_allowin_i(next_allowin), .next_valid_o(next_valid_o), .excep_flush_i(excep_flush),
    .ld_req_i(ld_req), .ld_op_i(ld_op), .addr_lo_i(addr_lo), .alu_res_i(alu_res),
    .payload_i(payload), .data_ok_i(data_ok), .rdata_i(rdata), .wb_data_o(wb_data_o),
    .payload_o(payload_o), .fwd_valid_o(fwd_valid_o), .fwd_busy_o(fwd_busy_o)
  );

  typedef struct {
    bit         rst;
    bit [1:0]   pv, lr;
    bit [5:0]   op;
    bit [3:0]   ad;
    bit [31:0]  a0, a1;
    bit [127:0] pay;
    bit         dok;
    bit [31:0]  rd;
    bit         nai, fl;
  } in_t;

  typedef struct {
    in_t       i;
    bit        aw;
    bit [1:0]  nv, bz, wm;
    bit [31:0] w0, w1;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Model: the held bundle plus flags for "a bus response is owed",
  // "that response belongs to a killed bundle" and "response already buffered".
  bit [1:0]  m_valid;
  bit [31:0] m_alu [2];
  bit [2:0]  m_op [2];
  bit [1:0]  m_ad [2];
  bit [63:0] m_pay [2];
  int        m_ll;
  bit        m_owed, m_dead, m_have;
  bit [31:0] m_data;

  function automatic bit [31:0] ld_val(bit [2:0] op, bit [1:0] a, bit [31:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return b;
      3'd2:    return (h >= 32768) ? h - 65536 : h;
      3'd3:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic in_t idle_in();
    in_t x;
    x = '{default: '0};
    x.nai = 1'b1;
    return x;
  endfunction

  function automatic vec_t mk(bit [1:0] pv, bit [1:0] lr, bit [5:0] op, bit [3:0] ad,
                              bit [31:0] a0, bit [31:0] a1, bit dok, bit [31:0] rd,
                              bit nai, bit fl, bit aw, bit [1:0] nv, bit [1:0] bz,
                              bit [1:0] wm, bit [31:0] w0, bit [31:0] w1);
    vec_t v;
    v.i     = idle_in();
    v.i.pv  = pv;  v.i.lr = lr;  v.i.op = op;  v.i.ad = ad;
    v.i.a0  = a0;  v.i.a1 = a1;  v.i.dok = dok; v.i.rd = rd;
    v.i.nai = nai; v.i.fl = fl;
    v.i.pay = {a1, ~a1, a0, ~a0};
    v.aw = aw; v.nv = nv; v.bz = bz; v.wm = wm; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic drive(input in_t x);
    rst          = x.rst;
    pre_valid    = x.pv;
    ld_req       = x.lr;
    ld_op        = x.op;
    addr_lo      = x.ad;
    alu_res      = {x.a1, x.a0};
    payload      = x.pay;
    data_ok      = x.dok;
    rdata        = x.rd;
    next_allowin = x.nai;
    excep_flush  = x.fl;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_owed  = 1'b0;
    m_dead  = 1'b0;
    m_have  = 1'b0;
    m_data  = '0;
    m_ll    = -1;
    for (int l = 0; l < 2; l++) m_pay[l] = '0;
  endtask

  task automatic check_model();
    bit        lw, rdy, aw;
    bit [1:0]  nv, bz;
    bit [31:0] w;
    lw  = m_owed && !m_dead;
    rdy = !lw || data_ok;
    aw  = (m_valid == 0 || (rdy && next_allowin)) && !(m_owed && m_dead) && !excep_flush;
    nv  = (rdy && !excep_flush) ? m_valid : 2'b00;
    bz  = (lw && !data_ok) ? (m_valid & (2'b01 << m_ll)) : 2'b00;
    chk("m_allowin", 128'(now_allowin_o), 128'(aw));
    chk("m_next_valid", 128'(next_valid_o), 128'(nv));
    chk("m_fwd_valid", 128'(fwd_valid_o), 128'(nv));
    chk("m_fwd_busy", 128'(fwd_busy_o), 128'(bz));
    chk("m_payload", payload_o, {m_pay[1], m_pay[0]});
    for (int l = 0; l < 2; l++) begin
      if (!m_valid[l] || nv[l]) begin
        if (!m_valid[l])   w = '0;
        else if (l == m_ll) w = m_have ? m_data : ld_val(m_op[l], m_ad[l], rdata);
        else               w = m_alu[l];
        chk($sformatf("m_wb_data%0d", l), 128'(wb_data_o[l*32 +: 32]), 128'(w));
      end
    end
  endtask

  task automatic step();
    bit lw, rdy, allow;
    lw    = m_owed && !m_dead;
    rdy   = !lw || data_ok;
    allow = (m_valid == 0 || (rdy && next_allowin)) && !(m_owed && m_dead) && !excep_flush;
    if (rst) begin
      model_reset();
    end else if (excep_flush) begin
      if (m_owed && data_ok) begin
        m_owed = 1'b0;
        m_dead = 1'b0;
      end else if (m_owed) begin
        m_dead = 1'b1;
      end
      m_have  = 1'b0;
      m_valid = '0;
    end else begin
      if (m_owed && data_ok) begin
        if (!m_dead && !next_allowin) begin
          m_have = 1'b1;
          m_data = ld_val(m_op[m_ll], m_ad[m_ll], rdata);
        end
        m_owed = 1'b0;
        m_dead = 1'b0;
      end
      if (allow) begin
        m_valid = pre_valid;
        m_have  = 1'b0;
        if (pre_valid != 0) begin
          m_ll = -1;
          for (int l = 0; l < 2; l++) begin
            m_alu[l] = alu_res[l*32 +: 32];
            m_op[l]  = ld_op[l*3 +: 3];
            m_ad[l]  = addr_lo[l*2 +: 2];
            m_pay[l] = payload[l*64 +: 64];
            if (pre_valid[l] && ld_req[l]) begin
              m_ll   = l;
              m_owed = 1'b1;
            end
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_allowin"}, 128'(now_allowin_o), 128'(1));
    chk({tag, "_next_valid"}, 128'(next_valid_o), 128'(0));
    chk({tag, "_fwd_valid"}, 128'(fwd_valid_o), 128'(0));
    chk({tag, "_fwd_busy"}, 128'(fwd_busy_o), 128'(0));
    chk({tag, "_wb_data"}, 128'(wb_data_o), 128'(0));
    chk({tag, "_payload"}, payload_o, 128'(0));
  endtask

  vec_t tv[$];

  initial begin
    in_t h;
    // ALU bundle, then an idle row
    tv.push_back(mk(3, 0, 6'o00, 4'h0, 5, 7, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 3, 0, 3, 5, 7));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    // LB lane1 addr 3, three wait cycles
    tv.push_back(mk(2, 2, 6'o00, 4'hC, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'h80FF_0000, 1, 0,  1, 2, 0, 3, 0, 32'hFFFF_FF80));
    // LHU lane0 addr 2, WB stalls on data_ok, stray data_ok while held
    tv.push_back(mk(1, 1, 6'o03, 4'h2, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'h8001_1234, 0, 0,  0, 1, 0, 3, 32'h0000_8001, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 3, 32'h0000_8001, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0,  0, 1, 0, 3, 32'h0000_8001, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 3, 32'h0000_8001, 0));
    // LW flushed while pending, response drained later
    tv.push_back(mk(1, 1, 6'o04, 4'h0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 2, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 2, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'h1234_5678, 1, 0,  0, 0, 0, 3, 0, 0));
    tv.push_back(mk(3, 0, 6'o00, 4'h0, 32'h11, 32'h22, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 3, 0, 3, 32'h11, 32'h22));
    // Flush coinciding with data_ok, next bundle accepted
    tv.push_back(mk(1, 1, 6'o01, 4'h1, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'h0000_AB00, 1, 1,  0, 0, 0, 2, 0, 0));
    tv.push_back(mk(2, 0, 6'o00, 4'h0, 0, 32'h33, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 2, 0, 3, 0, 32'h33));
    // LH sign extension, then back-to-back loads
    tv.push_back(mk(2, 2, 6'o20, 4'h8, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'h8001_1234, 1, 0,  1, 2, 0, 3, 0, 32'hFFFF_8001));
    tv.push_back(mk(1, 1, 6'o04, 4'h0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(1, 1, 6'o01, 4'h0, 0, 0, 1, 32'hCAFE_F00D, 1, 0,  1, 1, 0, 3, 32'hCAFE_F00D, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 1, 32'h0000_00F0, 1, 0,  1, 1, 0, 3, 32'hF0, 0));
    // ALU bundle stalled by WB
    tv.push_back(mk(3, 0, 6'o00, 4'h0, 1, 2, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 3, 1, 2));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 3, 0, 3, 1, 2));
    tv.push_back(mk(0, 0, 6'o00, 4'h0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0));

    h = idle_in();
    h.rst = 1'b1;
    drive(h);
    repeat (2) @(negedge clk);
    model_reset();
    h.rst = 1'b0;
    drive(h);
    #1;
    chk_idle("reset");
    check_model();
    step();

    foreach (tv[k]) begin
      drive(tv[k].i);
      #1;
      check_model();
      chk($sformatf("row%0d_allowin", k), 128'(now_allowin_o), 128'(tv[k].aw));
      chk($sformatf("row%0d_next_valid", k), 128'(next_valid_o), 128'(tv[k].nv));
      chk($sformatf("row%0d_fwd_valid", k), 128'(fwd_valid_o), 128'(tv[k].nv));
      chk($sformatf("row%0d_fwd_busy", k), 128'(fwd_busy_o), 128'(tv[k].bz));
      if (tv[k].wm[0]) chk($sformatf("row%0d_wb0", k), 128'(wb_data_o[31:0]), 128'(tv[k].w0));
      if (tv[k].wm[1]) chk($sformatf("row%0d_wb1", k), 128'(wb_data_o[63:32]), 128'(tv[k].w1));
      step();
    end

    // Reset while a load waits, then a stray data_ok
    h = idle_in(); h.pv = 2; h.lr = 2; h.op = 6'o40;
    drive(h); #1; check_model(); step();
    h = idle_in();
    drive(h); #1; check_model();
    chk("t6_busy_before_rst", 128'(fwd_busy_o), 128'(2));
    step();
    h = idle_in(); h.rst = 1'b1;
    drive(h); #1; check_model(); step();
    h = idle_in(); h.dok = 1'b1; h.rd = 32'hFFFF_FFFF;
    drive(h); #1; chk_idle("t6_after_rst"); check_model(); step();
    h = idle_in(); h.pv = 1; h.a0 = 9;
    drive(h); #1; chk_idle("t6_stray_ignored"); check_model(); step();
    h = idle_in();
    drive(h); #1; check_model();
    chk("t6_nv", 128'(next_valid_o), 128'(1));
    chk("t6_wb", 128'(wb_data_o[31:0]), 128'(9));
    step();

    for (int n = 0; n < 3000; n++) begin
      h     = idle_in();
      h.rst = ($urandom_range(0, 99) == 0);
      h.pv  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) h.lr[$urandom_range(0, 1)] = 1'b1;
      h.op  = 6'($urandom);
      h.ad  = 4'($urandom);
      h.a0  = $urandom;
      h.a1  = $urandom;
      h.pay = {$urandom, $urandom, $urandom, $urandom};
      h.dok = ($urandom_range(0, 9) < 3);
      h.rd  = $urandom;
      h.nai = ($urandom_range(0, 3) != 0);
      h.fl  = ($urandom_range(0, 19) == 0);
      drive(h);
      #1;
      check_model();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
